// File: rtl/alu_multicycle.sv
// -----------------------------------------------------------------------------
// alu_multicycle
//
// Handshaked execute-stage ALU. Single-cycle operations (ADD, SUB, AND, OR,
// SLL, SRA) are registered on the accepting edge. MUL and DIV iterate one
// radix-2 step per clock over magnitudes and are sign-corrected when the last
// step completes. The pipeline presents an operation with in_valid, stalls
// while in_ready is low, and must capture the result on the one-cycle
// out_valid pulse; there is no output backpressure.
//
// Build option:
//   ALU_DIV_EN  when defined, the restoring divider (remainder register and
//               trial subtractor) is built. When undefined, no divide logic
//               exists and opcode 00111 completes in one cycle with result 0
//               and exception=1. MUL is unaffected either way.
//
// Parameters:
//   WIDTH    operand/result width (>= 4)
//   SHAMT_W  shift-amount width, derived from WIDTH
//
// Ports:
//   clock           sole clock, rising edge
//   reset           asynchronous, active-high
//   in_valid        operation presented
//   in_ready        block can accept (accept = in_valid && in_ready)
//   data_operandA   signed operand A
//   data_operandB   signed operand B
//   ctrl_ALUopcode  5-bit operation select
//   ctrl_shiftamt   shift amount for SLL/SRA
//   out_valid       one-cycle pulse: result and flags valid
//   data_result     result, held until the next completion
//   isNotEqual      A != B (from A-B)
//   isLessThan      A < B signed (overflow-corrected A-B sign)
//   overflow        signed overflow of the selected operation
//   exception       divide-by-zero, or DIV when the divider is not built
// -----------------------------------------------------------------------------
module alu_multicycle #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] data_operandA,
    input  logic signed [WIDTH-1:0] data_operandB,
    input  logic [4:0]              ctrl_ALUopcode,
    input  logic [SHAMT_W-1:0]      ctrl_shiftamt,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] data_result,
    output logic                    isNotEqual,
    output logic                    isLessThan,
    output logic                    overflow,
    output logic                    exception
);

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;
    localparam logic [4:0] OP_MUL = 5'b00110;
    localparam logic [4:0] OP_DIV = 5'b00111;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam int PW = 2 * WIDTH;
    localparam logic [SHAMT_W-1:0] LAST_STEP = SHAMT_W'(WIDTH - 1);

`ifdef ALU_DIV_EN
    localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    // -------------------------------------------------------------------------
    // Arithmetic helpers
    // -------------------------------------------------------------------------
    // Magnitude as an unsigned WIDTH-bit value; MIN maps to 2^(WIDTH-1),
    // which is representable unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    function automatic logic addOverflow(input logic signed [WIDTH-1:0] a,
                                         input logic signed [WIDTH-1:0] b,
                                         input logic signed [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    function automatic logic subOverflow(input logic signed [WIDTH-1:0] a,
                                         input logic signed [WIDTH-1:0] b,
                                         input logic signed [WIDTH-1:0] d);
        return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
    endfunction

    // The product fits in WIDTH signed bits only if its top WIDTH+1 bits are
    // a pure sign extension.
    function automatic logic mulOverflow(input logic [PW-1:0] p);
        logic [WIDTH:0] upper;
        upper = p[PW-1:WIDTH-1];
        return !((&upper) || !(|upper));
    endfunction

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    logic [0:0]         state;
    logic [SHAMT_W-1:0] stepCount;
    logic               accept;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    // -------------------------------------------------------------------------
    // Accept stage: single-cycle results and compare flags
    // -------------------------------------------------------------------------
    logic signed [WIDTH-1:0] sum;
    logic signed [WIDTH-1:0] diff;
    logic                    ovfAdd;
    logic                    ovfSub;
    logic                    cmpNe;
    logic                    cmpLt;
    logic [WIDTH-1:0]        magA;
    logic [WIDTH-1:0]        magB;

    assign sum    = data_operandA + data_operandB;
    assign diff   = data_operandA - data_operandB;
    assign ovfAdd = addOverflow(data_operandA, data_operandB, sum);
    assign ovfSub = subOverflow(data_operandA, data_operandB, diff);
    assign cmpNe  = |diff;
    // Sign of A-B is wrong exactly when the subtraction overflowed.
    assign cmpLt  = diff[WIDTH-1] ^ ovfSub;
    assign magA   = magnitude(data_operandA);
    assign magB   = magnitude(data_operandB);

    logic signed [WIDTH-1:0] quickResult;
    logic                    quickOvf;
    logic                    quickExc;
    logic                    startIter;

    always_comb begin
        quickResult = '0;
        quickOvf    = 1'b0;
        quickExc    = 1'b0;
        startIter   = 1'b0;
        case (ctrl_ALUopcode)
            OP_ADD: begin
                quickResult = sum;
                quickOvf    = ovfAdd;
            end
            OP_SUB: begin
                quickResult = diff;
                quickOvf    = ovfSub;
            end
            OP_AND: quickResult = data_operandA & data_operandB;
            OP_OR:  quickResult = data_operandA | data_operandB;
            OP_SLL: quickResult = data_operandA << ctrl_shiftamt;
            OP_SRA: quickResult = data_operandA >>> ctrl_shiftamt;
            OP_MUL: startIter = 1'b1;
            OP_DIV: begin
`ifdef ALU_DIV_EN
                // Divide-by-zero resolves immediately instead of iterating.
                if (data_operandB == '0) begin
                    quickExc = 1'b1;
                end else begin
                    startIter = 1'b1;
                end
`else
                quickExc = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Iterative stage: shift-add multiply over magnitudes
    // -------------------------------------------------------------------------
    // mulAcc = {partial high (WIDTH+1), multiplier / product low (WIDTH)}.
    logic [PW:0]        mulAcc;
    logic [WIDTH-1:0]   mulCand;
    logic               negResult;
    logic               pendNe;
    logic               pendLt;
    logic [WIDTH:0]     hiSum;
    logic [PW:0]        mulNext;
    logic [PW-1:0]      prodMag;
    logic [PW-1:0]      prodSigned;

    assign hiSum      = mulAcc[PW:WIDTH] + (mulAcc[0] ? {1'b0, mulCand} : {(WIDTH+1){1'b0}});
    assign mulNext    = {1'b0, hiSum, mulAcc[WIDTH-1:1]};
    assign prodMag    = mulNext[PW-1:0];
    assign prodSigned = negResult ? -prodMag : prodMag;

`ifdef ALU_DIV_EN
    // -------------------------------------------------------------------------
    // Iterative stage: restoring divide over magnitudes
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] divRem;
    logic [WIDTH-1:0] divQuot;
    logic [WIDTH-1:0] divisor;
    logic             busyIsDiv;
    logic             divOvfPend;
    logic [WIDTH:0]   remShift;
    logic             remGeq;
    logic [WIDTH-1:0] remNext;
    logic [WIDTH-1:0] quotNext;
    logic [WIDTH-1:0] quotSigned;

    assign remShift   = {divRem, divQuot[WIDTH-1]};
    assign remGeq     = remShift >= {1'b0, divisor};
    // When the trial subtract succeeds the difference is below the divisor,
    // so the low WIDTH bits are exact.
    assign remNext    = remGeq ? (remShift[WIDTH-1:0] - divisor) : remShift[WIDTH-1:0];
    assign quotNext   = {divQuot[WIDTH-2:0], remGeq};
    assign quotSigned = negResult ? -quotNext : quotNext;
`endif

    logic signed [WIDTH-1:0] busyResult;
    logic                    busyOvf;

    always_comb begin
        busyResult = prodSigned[WIDTH-1:0];
        busyOvf    = mulOverflow(prodSigned);
`ifdef ALU_DIV_EN
        if (busyIsDiv) begin
            // MIN / -1 yields the magnitude 2^(WIDTH-1), which already reads
            // back as MIN; only the flag needs forcing.
            busyResult = quotSigned;
            busyOvf    = divOvfPend;
        end
`endif
    end

    // Datapath working registers carry no reset; they are always loaded on
    // accept before being read.
    always_ff @(posedge clock) begin
        if (state == IDLE) begin
            if (accept && startIter) begin
                mulAcc    <= {{(WIDTH+1){1'b0}}, magB};
                mulCand   <= magA;
                negResult <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                pendNe    <= cmpNe;
                pendLt    <= cmpLt;
`ifdef ALU_DIV_EN
                busyIsDiv  <= (ctrl_ALUopcode == OP_DIV);
                divOvfPend <= (data_operandA == MIN_VAL) && (data_operandB == '1);
                divRem     <= '0;
                divQuot    <= magA;
                divisor    <= magB;
`endif
            end
        end else begin
            mulAcc <= mulNext;
`ifdef ALU_DIV_EN
            divRem  <= remNext;
            divQuot <= quotNext;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Output stage: registered result and flags, held until next completion
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            stepCount   <= '0;
            out_valid   <= 1'b0;
            data_result <= '0;
            isNotEqual  <= 1'b0;
            isLessThan  <= 1'b0;
            overflow    <= 1'b0;
            exception   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    if (startIter) begin
                        state     <= BUSY;
                        stepCount <= LAST_STEP;
                    end else begin
                        out_valid   <= 1'b1;
                        data_result <= quickResult;
                        isNotEqual  <= cmpNe;
                        isLessThan  <= cmpLt;
                        overflow    <= quickOvf;
                        exception   <= quickExc;
                    end
                end
            end else begin
                stepCount <= stepCount - SHAMT_W'(1);
                if (stepCount == '0) begin
                    state       <= IDLE;
                    stepCount   <= '0;
                    out_valid   <= 1'b1;
                    data_result <= busyResult;
                    isNotEqual  <= pendNe;
                    isLessThan  <= pendLt;
                    overflow    <= busyOvf;
                    exception   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// -----------------------------------------------------------------------------
// tb_alu_multicycle
//
// Drives a 32-bit and an 8-bit alu_multicycle from one directed sequence
// plus randomized operations, comparing every completion against an
// arithmetic reference model of the opcode table.
// -----------------------------------------------------------------------------
module tb_alu_multicycle;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_SLL = 5'd4;
    localparam logic [4:0] OP_SRA = 5'd5;
    localparam logic [4:0] OP_MUL = 5'd6;
    localparam logic [4:0] OP_DIV = 5'd7;

`ifdef ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    logic        iv32, ir32, ov32, ne32, lt32, of32, ex32;
    logic [31:0] a32, b32, r32;
    logic [4:0]  op32, sh32;

    logic        iv8, ir8, ov8, ne8, lt8, of8, ex8;
    logic [7:0]  a8, b8, r8;
    logic [4:0]  op8;
    logic [2:0]  sh8;

    alu_multicycle #(.WIDTH(32)) dut32 (
        .clock(clock), .reset(reset),
        .in_valid(iv32), .in_ready(ir32),
        .data_operandA(a32), .data_operandB(b32),
        .ctrl_ALUopcode(op32), .ctrl_shiftamt(sh32),
        .out_valid(ov32), .data_result(r32),
        .isNotEqual(ne32), .isLessThan(lt32),
        .overflow(of32), .exception(ex32)
    );

    alu_multicycle #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset),
        .in_valid(iv8), .in_ready(ir8),
        .data_operandA(a8), .data_operandB(b8),
        .ctrl_ALUopcode(op8), .ctrl_shiftamt(sh8),
        .out_valid(ov8), .data_result(r8),
        .isNotEqual(ne8), .isLessThan(lt8),
        .overflow(of8), .exception(ex8)
    );

    int tests = 0;
    int fails = 0;

    // Selected-DUT view
    bit          useSmall = 1'b0;
    logic        obsReady, obsValid, obsNe, obsLt, obsOvf, obsExc;
    logic [31:0] obsRes;

    always_comb begin
        if (useSmall) begin
            obsReady = ir8;  obsValid = ov8;  obsRes = {24'b0, r8};
            obsNe = ne8; obsLt = lt8; obsOvf = of8; obsExc = ex8;
        end else begin
            obsReady = ir32; obsValid = ov32; obsRes = r32;
            obsNe = ne32; obsLt = lt32; obsOvf = of32; obsExc = ex32;
        end
    end

    // Record every 32-bit completion, in order
    logic [31:0] pulses32[$];
    always @(negedge clock) begin
        if (ov32 === 1'b1) pulses32.push_back(r32);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: mathematical result on sign-extended operands, then
    // truncated to w bits; overflow means "not representable in w bits".
    task automatic refModel(input int w, input logic [4:0] op, input longint a, input longint b,
                            input int sh, output logic [31:0] res, output logic ne,
                            output logic lt, output logic ovf, output logic exc,
                            output int edges);
        longint minV, maxV, v, mask;
        minV  = -(longint'(1) << (w - 1));
        maxV  = (longint'(1) << (w - 1)) - 1;
        mask  = (longint'(1) << w) - 1;
        v     = 0;
        ne    = (a != b);
        lt    = (a < b);
        ovf   = 1'b0;
        exc   = 1'b0;
        edges = 0;
        case (op)
            OP_ADD: begin v = a + b; ovf = (v < minV) || (v > maxV); end
            OP_SUB: begin v = a - b; ovf = (v < minV) || (v > maxV); end
            OP_AND: v = a & b;
            OP_OR:  v = a | b;
            OP_SLL: v = a << sh;
            OP_SRA: v = a >>> sh;
            OP_MUL: begin v = a * b; ovf = (v < minV) || (v > maxV); edges = w; end
            OP_DIV: begin
                if (b == 0 || !DIV_EN) begin
                    v = 0; exc = 1'b1;
                end else begin
                    v = a / b; ovf = (v > maxV); edges = w;
                end
            end
            default: v = 0;
        endcase
        res = 32'(v & mask);
    endtask

    task automatic drive(input int w, input logic vld, input logic [4:0] op,
                         input longint a, input longint b, input int sh);
        if (w == 8) begin
            iv8 = vld; op8 = op; a8 = a[7:0]; b8 = b[7:0]; sh8 = sh[2:0];
        end else begin
            iv32 = vld; op32 = op; a32 = a[31:0]; b32 = b[31:0]; sh32 = sh[4:0];
        end
    endtask

    task automatic dropValid(input int w);
        if (w == 8) iv8 = 1'b0; else iv32 = 1'b0;
    endtask

    // Issue one op (called #1 after a rising edge) and check its completion.
    task automatic runOp(input int w, input logic [4:0] op, input longint a, input longint b,
                         input int sh, input string tag);
        logic [31:0] eRes;
        logic        eNe, eLt, eOvf, eExc;
        int          eEdges, guard, lat;
        bit          busyOk;
        refModel(w, op, a, b, sh, eRes, eNe, eLt, eOvf, eExc, eEdges);
        useSmall = (w == 8);
        #0;
        guard = 0;
        while (obsReady !== 1'b1 && guard < 100) begin
            @(posedge clock); #1; guard++;
        end
        check({tag, " ready"}, 32'(obsReady), 32'd1);
        drive(w, 1'b1, op, a, b, sh);
        @(posedge clock); #1;
        dropValid(w);
        lat = 0;
        busyOk = 1'b1;
        while (obsValid !== 1'b1 && lat < eEdges + 4) begin
            if (obsReady !== 1'b0) busyOk = 1'b0;
            @(posedge clock); #1; lat++;
        end
        check({tag, " valid"}, 32'(obsValid), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(eEdges));
        if (eEdges > 0) check({tag, " busy"}, 32'(busyOk), 32'd1);
        check({tag, " result"}, obsRes, eRes);
        check({tag, " ne"}, 32'(obsNe), 32'(eNe));
        check({tag, " lt"}, 32'(obsLt), 32'(eLt));
        check({tag, " ovf"}, 32'(obsOvf), 32'(eOvf));
        check({tag, " exc"}, 32'(obsExc), 32'(eExc));
        @(posedge clock); #1;
        check({tag, " pulse"}, 32'(obsValid), 32'd0);
    endtask

    function automatic longint randOperand(input int w);
        logic [31:0] r;
        int          pick;
        r    = $urandom;
        pick = $urandom_range(0, 7);
        case (pick)
            0: r = 32'd0;
            1: r = 32'hFFFF_FFFF;
            2: r = 32'd1 << (w - 1);
            3: r = (32'd1 << (w - 1)) - 32'd1;
            4: r = 32'($urandom_range(1, 20));
            5: r = -32'($urandom_range(1, 20));
            default: ;
        endcase
        if (w == 8) return longint'($signed(r[7:0]));
        return longint'($signed(r));
    endfunction

    initial begin
        logic [31:0] eRes;
        logic        eNe, eLt, eOvf, eExc;
        int          eEdges, base, guard;
        logic [31:0] expQ[4];

        reset = 1'b1;
        drive(32, 1'b0, OP_ADD, 0, 0, 0);
        drive(8, 1'b0, OP_ADD, 0, 0, 0);
        repeat (3) @(posedge clock);
        #1;
        check("rst ready32", 32'(ir32), 32'd1);
        check("rst valid32", 32'(ov32), 32'd0);
        check("rst result32", r32, 32'd0);
        check("rst flags32", {28'd0, ne32, lt32, of32, ex32}, 32'd0);
        check("rst ready8", 32'(ir8), 32'd1);
        check("rst result8", {24'd0, r8}, 32'd0);
        check("rst flags8", {28'd0, ov8, ne8, of8, ex8}, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Directed cases
        runOp(32, OP_ADD, 64'sh7FFF_FFFF, 1, 0, "add ovf");
        check("add ovf literal", r32, 32'h8000_0000);
        check("add ovf flag literal", 32'(of32), 32'd1);
        runOp(32, OP_SUB, 5, 7, 0, "sub 5-7");
        check("sub literal", r32, 32'hFFFF_FFFE);
        runOp(32, OP_MUL, -3, 7, 0, "mul -3x7");
        check("mul literal", r32, 32'hFFFF_FFEB);
        runOp(32, OP_MUL, 64'sh1_0000, 64'sh1_0000, 0, "mul ovf");
        runOp(32, OP_DIV, -7, 2, 0, "div -7/2");
        runOp(32, OP_DIV, -64'sh8000_0000, -1, 0, "div min/-1");
        runOp(32, OP_DIV, 9, 0, 0, "div 9/0");
        runOp(32, OP_SRA, -64'sh8000_0000, 0, 4, "sra");
        check("sra literal", r32, 32'hF800_0000);
        runOp(32, OP_SLL, 3, 0, 31, "sll top");
        runOp(32, 5'd9, 4, 9, 0, "undef op");
        runOp(8, OP_MUL, -128, 1, 0, "mul8 -128x1");
        check("mul8 literal", {24'd0, r8}, 32'h80);
        runOp(8, OP_DIV, 6, 3, 0, "div8 6/3");

        // Reset 10 cycles into a MUL aborts it
        useSmall = 1'b0;
        base = pulses32.size();
        drive(32, 1'b1, OP_MUL, 100, 200, 0);
        @(posedge clock); #1;
        dropValid(32);
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("abort ready", 32'(ir32), 32'd1);
        check("abort valid", 32'(ov32), 32'd0);
        check("abort result", r32, 32'd0);
        check("abort flags", {28'd0, ne32, lt32, of32, ex32}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        check("abort no pulse", 32'(pulses32.size() - base), 32'd0);
        runOp(32, OP_ADD, 2, 2, 0, "add after abort");

        // Back-to-back single-cycle ops, then MUL with in_valid held while busy
        base = pulses32.size();
        refModel(32, OP_ADD, 10, 20, 0, expQ[0], eNe, eLt, eOvf, eExc, eEdges);
        refModel(32, OP_AND, 64'hF0F0, 64'hFF00, 0, expQ[1], eNe, eLt, eOvf, eExc, eEdges);
        refModel(32, OP_SRA, -64'sh8000_0000, 0, 4, expQ[2], eNe, eLt, eOvf, eExc, eEdges);
        refModel(32, OP_MUL, 6, -7, 0, expQ[3], eNe, eLt, eOvf, eExc, eEdges);
        drive(32, 1'b1, OP_ADD, 10, 20, 0);
        @(posedge clock); #1;
        drive(32, 1'b1, OP_AND, 64'hF0F0, 64'hFF00, 0);
        @(posedge clock); #1;
        drive(32, 1'b1, OP_SRA, -64'sh8000_0000, 0, 4);
        @(posedge clock); #1;
        drive(32, 1'b1, OP_MUL, 6, -7, 0);
        @(posedge clock); #1;
        guard = 0;
        while (ir32 !== 1'b1 && guard < 100) begin
            @(posedge clock); #1; guard++;
        end
        dropValid(32);
        check("b2b busy cycles", 32'(guard), 32'd32);
        repeat (3) @(posedge clock);
        #1;
        check("b2b pulse count", 32'(pulses32.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < pulses32.size())
                check($sformatf("b2b pulse%0d", i), pulses32[base + i], expQ[i]);
            else
                check($sformatf("b2b pulse%0d missing", i), 32'hDEAD_0000, expQ[i]);
        end

        // Randomized operations on both widths
        for (int i = 0; i < 60; i++) begin
            int         w;
            int         pick;
            logic [4:0] op;
            longint     a, b;
            int         sh;
            w    = (i % 2 == 0) ? 32 : 8;
            pick = $urandom_range(0, 11);
            op   = (pick < 8) ? 5'(pick) : 5'($urandom_range(8, 31));
            a    = randOperand(w);
            b    = randOperand(w);
            sh   = $urandom_range(0, w - 1);
            runOp(w, op, a, b, sh, $sformatf("rand%0d w%0d op%0d", i, w, op));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, handshaked ALU that extends the processor's single-cycle integer ALU. It adds registered outputs, iterative signed multiply and divide, and a divide-by-zero exception. It sits in the execute stage: the pipeline issues one operation with `in_valid`, stalls while `in_ready` is low, and captures the one-cycle `out_valid` result.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width; must be ≥ 4.
- `SHAMT_W`, default `$clog2(WIDTH)`: shift-amount width, derived; never overridden.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  block can accept; an operation is accepted on an edge where `in_valid && in_ready`.
- `data_operandA`, `data_operandB`  in  WIDTH  signed two's-complement operands.
- `ctrl_ALUopcode`  in  5  operation select.
- `ctrl_shiftamt`  in  SHAMT_W  shift amount.
- `out_valid`  out  1  one-cycle pulse; result and flags are valid.
- `data_result`  out  WIDTH  result.
- `isNotEqual`, `isLessThan`  out  1  signed comparison of A against B, computed as A−B.
- `overflow`  out  1  signed overflow.
- `exception`  out  1  divide-by-zero, or opcode disabled by configuration.

## Operation
Opcodes and results:
- `00000` ADD: A+B.
- `00001` SUB: A−B.
- `00010` AND: A&B.
- `00011` OR: A|B.
- `00100` SLL: A<<shamt.
- `00101` SRA: A>>>shamt, sign-filled.
- `00110` MUL: low WIDTH bits of the signed product.
- `00111` DIV: signed quotient, truncated toward zero.
- `01000`–`11111`: result 0, no flags other than compare.

State machine:
- IDLE: `in_ready`=1. Accepting a single-cycle op registers result and flags and stays in IDLE. Accepting MUL/DIV loads operand magnitudes and signs, sets iteration counter = WIDTH−1, and goes to BUSY.
- BUSY: `in_ready`=0. One radix-2 step per edge: shift-add for MUL, restoring subtract for DIV. On the edge where counter = 0, the sign-corrected result and flags are registered and the state returns to IDLE.

Flag rules:
- Compare flags: `isNotEqual`/`isLessThan` are evaluated at accept for every opcode, overflow-corrected as `(A−B)[MSB] XOR ovf_sub`.
- ADD/SUB: `overflow` is the signed carry-out rule for the selected add/subtract.
- MUL: `overflow`=1 when the full 2·WIDTH product's upper WIDTH+1 bits are not all equal.
- DIV by zero: result 0, `exception`=1, `overflow`=0. This takes the 1-cycle path; no BUSY.
- DIV of MIN by −1: result MIN, `overflow`=1. This takes the full iterative latency.
- All other cases: `overflow`=0 and `exception`=0.

Output holding and contention:
- `data_result` and all flags hold their last values until the next completion.
- `in_valid` while `in_ready`=0 is ignored; the issuer must hold it.
- There is no output backpressure: the consumer must capture on `out_valid`.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `data_result`=0, and all flags 0. State is IDLE and the counter is 0.
- Single-cycle ops: accepted on edge k, so `out_valid`=1 during the cycle after edge k.
- MUL/DIV: accepted on edge k, so `in_ready`=0 after edges k…k+WIDTH−1. The result is registered on edge k+WIDTH, with `out_valid`=1 and `in_ready`=1 in the following cycle. Latency is WIDTH cycles.
- Back-to-back: a new op may be accepted on the edge ending an `out_valid` cycle, giving one op per cycle for single-cycle ops.
- `reset` mid-BUSY immediately aborts to IDLE; that op never produces `out_valid`.

## Configuration
- `ALU_DIV_EN` defined: the DIV datapath (remainder register, restoring subtractor) is built as above.
- `ALU_DIV_EN` undefined:
  - No divide logic is instantiated.
  - Opcode `00111` completes in 1 cycle with result 0 and `exception`=1.
  - MUL is unaffected.

## Test plan
- ADD `0x7FFFFFFF`+`0x00000001` → `0x80000000`, `overflow`=1, `out_valid` exactly 1 cycle after accept. SUB 5−7 → `0xFFFFFFFE`, `isLessThan`=1, `isNotEqual`=1.
- MUL −3×7 → `0xFFFFFFEB`, `overflow`=0, `out_valid` 32 cycles after accept, `in_ready`=0 throughout. MUL `0x00010000`×`0x00010000` → `0x00000000`, `overflow`=1.
- DIV −7/2 → `0xFFFFFFFD`. DIV `0x80000000`/−1 → `0x80000000`, `overflow`=1. DIV 9/0 → 0 with `exception`=1, 1-cycle.
- Assert `reset` 10 cycles into a MUL → outputs 0, `in_ready`=1, no `out_valid`. A following ADD 2+2 → 4.
- Back-to-back ADD, AND, SRA (`0x80000000`>>>4 → `0xF8000000`), then MUL with `in_valid` held during BUSY → exactly four `out_valid` pulses, in order.
- `WIDTH`=8, `ALU_DIV_EN` undefined: MUL −128×1 → `0x80` after 8 cycles. DIV 6/3 → 0 with `exception`=1.
